// File: rtl/crypto_ctrl_pkg.sv
// Shared definitions for the crypto-core control slice.
// Holds the command-arbiter state encoding, the default command width and
// holdoff length, and a small index-wrap helper used by the arbiter.
package crypto_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam int DEF_LOG_COMMAND = 64;
  localparam int DEF_HOLDOFF     = 3;

  // Next requester index after idx, wrapping at n (n is 2..4).
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int n);
    logic [1:0] nxt;
    if (idx == 2'(n - 1)) begin
      nxt = 2'd0;
    end else begin
      nxt = idx + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   elig   - per-requester eligibility
//   rr_ptr - index that has first claim this round
//   pick   - first eligible index at or above rr_ptr, wrapping
//   any    - at least one requester is eligible
module rr_pick
  import crypto_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [1:0]         rr_ptr,
  output logic [1:0]         pick,
  output logic               any
);

  logic [3:0] elig_pad_s;
  logic [1:0] idx_s;

  // Walk the requesters starting at rr_ptr; the first eligible one wins.
  always_comb begin
    elig_pad_s = 4'(elig);
    pick       = 2'd0;
    any        = 1'b0;
    idx_s      = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = 2'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any && elig_pad_s[idx_s]) begin
        pick = idx_s;
        any  = 1'b1;
      end else begin
        pick = pick;
      end
    end
  end

endmodule

// File: rtl/core_cmd_arbiter.sv
// Shares the crypto core command port between NUM_REQ program controllers.
// One command is granted at a time in round-robin order, strobed to the
// core, and completion is returned to the owning requester. A watchdog
// releases the requester and raises a sticky flag if the core never answers.
// Ports:
//   clk, rst         - clock, asynchronous active-low reset
//   req_cmd, req_we  - per-requester command slices and level requests
//   req_done         - one-cycle completion pulse to the owner
//   core_cmd/we/done - command word, command strobe, completion from core
//   busy, owner      - activity flag and current/last granted index
//   timeout_err      - sticky watchdog flag
//   busy_cycles      - wrapping count of cycles spent in ISSUE or WAIT
module core_cmd_arbiter
  import crypto_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int LOG_COMMAND = DEF_LOG_COMMAND,
  parameter int HOLDOFF     = DEF_HOLDOFF,
  parameter int TIMEOUT_W   = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*LOG_COMMAND-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]             req_we,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [LOG_COMMAND-1:0]         core_cmd,
  output logic                           core_we,
  input  logic                           core_done,
  output logic                           busy,
  output logic [1:0]                     owner,
  output logic                           timeout_err,
  output logic [30:0]                    busy_cycles
);

  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLDOFF);
  // Watchdog value one step before all-ones: the increment from here times out.
  localparam logic [TIMEOUT_W-1:0] WD_LAST   = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  arb_state_e               state_r, state_s;
  logic [NUM_REQ-1:0]       elig_s;
  logic [HOLD_W-1:0]        hold_cnt_r [NUM_REQ];
  logic [1:0]               pick_s, rr_ptr_r, owner_r;
  logic                     any_s, timeout_hit_s;
  logic [LOG_COMMAND-1:0]   sel_cmd_s, cmd_r;
  logic [TIMEOUT_W-1:0]     wd_r;
  logic [NUM_REQ-1:0]       done_vec_s, req_done_r;
  logic                     core_we_r, busy_r, timeout_err_r;
  logic [30:0]              busy_cycles_r;

  // Eligibility: requesting and not inside its post-completion holdoff.
  always_comb begin
    elig_s     = {NUM_REQ{1'b0}};
    done_vec_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i]     = req_we[i] & (hold_cnt_r[i] == {HOLD_W{1'b0}});
      done_vec_s[i] = (owner_r == 2'(i));
    end
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .elig   (elig_s),
    .rr_ptr (rr_ptr_r),
    .pick   (pick_s),
    .any    (any_s)
  );

  // Command slice of the picked requester.
  always_comb begin
    sel_cmd_s = {LOG_COMMAND{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_s == 2'(i)) begin
        sel_cmd_s = req_cmd[i*LOG_COMMAND +: LOG_COMMAND];
      end else begin
        sel_cmd_s = sel_cmd_s;
      end
    end
  end

  // Next-state logic; core_done only matters in WAIT and beats the watchdog.
  always_comb begin
    state_s       = state_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          state_s = ST_DONE;
        end else if (wd_r == WD_LAST) begin
          state_s       = ST_DONE;
          timeout_hit_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant capture: command and owner are frozen for the whole transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_r   <= {LOG_COMMAND{1'b0}};
      owner_r <= 2'd0;
    end else if (state_r == ST_IDLE && any_s) begin
      cmd_r   <= sel_cmd_s;
      owner_r <= pick_s;
    end else begin
      cmd_r   <= cmd_r;
      owner_r <= owner_r;
    end
  end

  // Round-robin pointer moves past the owner once its command completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= 2'd0;
    end else if (state_r == ST_DONE) begin
      rr_ptr_r <= wrap_inc(owner_r, NUM_REQ);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Holdoff counters: reload for the owner in DONE, otherwise count to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_cnt_r[i] <= {HOLD_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (state_r == ST_DONE && owner_r == 2'(i)) begin
          hold_cnt_r[i] <= HOLD_LOAD;
        end else if (hold_cnt_r[i] != {HOLD_W{1'b0}}) begin
          hold_cnt_r[i] <= hold_cnt_r[i] - HOLD_W'(1'b1);
        end else begin
          hold_cnt_r[i] <= hold_cnt_r[i];
        end
      end
    end
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_r          <= {TIMEOUT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      if (state_r == ST_ISSUE) begin
        wd_r <= {TIMEOUT_W{1'b0}};
      end else if (state_r == ST_WAIT && !core_done) begin
        wd_r <= wd_r + TIMEOUT_W'(1'b1);
      end else begin
        wd_r <= wd_r;
      end
      timeout_err_r <= timeout_err_r | timeout_hit_s;
    end
  end

  // Output registers, driven from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_we_r     <= 1'b0;
      req_done_r    <= {NUM_REQ{1'b0}};
      busy_r        <= 1'b0;
      busy_cycles_r <= 31'd0;
    end else begin
      core_we_r  <= (state_s == ST_ISSUE);
      req_done_r <= (state_s == ST_DONE) ? done_vec_s : {NUM_REQ{1'b0}};
      busy_r     <= (state_s != ST_IDLE);
      if (state_r == ST_ISSUE || state_r == ST_WAIT) begin
        busy_cycles_r <= busy_cycles_r + 31'd1;
      end else begin
        busy_cycles_r <= busy_cycles_r;
      end
    end
  end

  assign core_cmd    = cmd_r;
  assign core_we     = core_we_r;
  assign req_done    = req_done_r;
  assign busy        = busy_r;
  assign owner       = owner_r;
  assign timeout_err = timeout_err_r;
  assign busy_cycles = busy_cycles_r;

endmodule

// File: tb/tb_core_cmd_arbiter.sv
// Directed plus randomized bench for core_cmd_arbiter (NUM_REQ=2, HOLDOFF=3,
// TIMEOUT_W=4). Expected grants and timing come from a transaction-level
// model: grant cycle is the earliest cycle a requester is both requesting
// and past its holdoff, ties resolved by searching from the pointer.
module tb_core_cmd_arbiter;

  localparam int NREQ = 2;
  localparam int LC   = 64;
  localparam int HOLD = 3;
  localparam int TW   = 4;
  localparam int WD_WAIT = (1 << TW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ*LC-1:0] req_cmd;
  logic [NREQ-1:0]   req_we;
  logic [NREQ-1:0]   req_done;
  logic [LC-1:0]     core_cmd;
  logic              core_we;
  logic              core_done;
  logic              busy;
  logic [1:0]        owner;
  logic              timeout_err;
  logic [30:0]       busy_cycles;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int   ready_at [NREQ];
  int   ptr;
  int   exp_busy;
  logic exp_to;

  always #5 clk = ~clk;

  core_cmd_arbiter #(
    .NUM_REQ(NREQ), .LOG_COMMAND(LC), .HOLDOFF(HOLD), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_we(req_we),
    .req_done(req_done), .core_cmd(core_cmd), .core_we(core_we),
    .core_done(core_done), .busy(busy), .owner(owner),
    .timeout_err(timeout_err), .busy_cycles(busy_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic model_reset();
    ptr = 0;
    exp_busy = 0;
    exp_to = 1'b0;
    for (int i = 0; i < NREQ; i++) ready_at[i] = 0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_done"}, 64'(req_done), 64'(0));
    chk({tag, "_core_cmd"}, core_cmd, 64'(0));
    chk({tag, "_core_we"}, 64'(core_we), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_owner"}, 64'(owner), 64'(0));
    chk({tag, "_timeout"}, 64'(timeout_err), 64'(0));
    chk({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(0));
  endtask

  // Earliest eligible cycle among requesters in mask, winner by pointer order.
  task automatic model_pick(input logic [1:0] mask, input int c, output int g, output int w);
    int t;
    bit found;
    g = 1 << 30;
    for (int i = 0; i < NREQ; i++) begin
      t = (ready_at[i] > c) ? ready_at[i] : c;
      if (mask[i] && t < g) g = t;
    end
    w = 0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      t = (ready_at[i] > c) ? ready_at[i] : c;
      if (!found && mask[i] && t <= g) begin
        w = i;
        found = 1'b1;
      end
    end
  endtask

  // One transaction; lat=0 means the core never answers (watchdog path).
  task automatic run_txn(input logic [1:0] mask, input int gap, input int lat,
                         input bit drop, input bit spur, input bit fix0,
                         input logic [63:0] cmd0,
                         output logic [1:0] got_owner, output int issue_off);
    int c, g, w, d;
    logic [63:0] cmd_v [NREQ];
    logic [1:0]  exp_done;
    for (int k = 0; k < gap; k++) begin
      req_we = 2'b00;
      next_cycle();
    end
    c = cyc;
    for (int i = 0; i < NREQ; i++) begin
      cmd_v[i] = {$urandom, $urandom};
      if (fix0 && i == 0) cmd_v[i] = cmd0;
      req_cmd[i*LC +: LC] = cmd_v[i];
    end
    req_we = mask;
    model_pick(mask, c, g, w);
    while (cyc < g) begin
      next_cycle();
      chk("idle_no_we", 64'(core_we), 64'(0));
    end
    next_cycle();
    chk("issue_we", 64'(core_we), 64'(1));
    chk("issue_cmd", core_cmd, cmd_v[w]);
    chk("issue_owner", 64'(owner), 64'(w));
    chk("issue_busy", 64'(busy), 64'(1));
    got_owner = owner;
    issue_off = cyc - c;
    if (drop) req_we[w] = 1'b0;
    req_cmd = {$urandom, $urandom, $urandom, $urandom};
    core_done = spur;
    d = (lat > 0) ? (g + 1 + lat) : (g + 1 + WD_WAIT);
    next_cycle();
    core_done = 1'b0;
    chk("wait_we_low", 64'(core_we), 64'(0));
    chk("wait_cmd_hold", core_cmd, cmd_v[w]);
    while (cyc < d) begin
      chk("wait_no_done", 64'(req_done), 64'(0));
      next_cycle();
    end
    chk("wait_timeout", 64'(timeout_err), 64'(exp_to));
    core_done = (lat > 0);
    next_cycle();
    core_done = 1'b0;
    if (lat == 0) exp_to = 1'b1;
    exp_busy = exp_busy + (d - g);
    exp_done = 2'b00;
    exp_done[w] = 1'b1;
    chk("done_pulse", 64'(req_done), 64'(exp_done));
    chk("done_timeout", 64'(timeout_err), 64'(exp_to));
    chk("done_busy_cycles", 64'(busy_cycles), 64'(exp_busy));
    chk("done_busy", 64'(busy), 64'(1));
    ready_at[w] = d + 2 + HOLD;
    ptr = (w + 1) % NREQ;
    next_cycle();
    chk("after_done_low", 64'(req_done), 64'(0));
    chk("after_busy_low", 64'(busy), 64'(0));
    req_we = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [1:0] o;
    int off;
    rst = 1'b0;
    req_cmd = '0;
    req_we = 2'b00;
    core_done = 1'b0;
    model_reset();
    next_cycle();
    next_cycle();
    chk_zero_outputs("reset");
    rst = 1'b1;
    next_cycle();

    // core_done while IDLE must be ignored
    core_done = 1'b1;
    next_cycle();
    core_done = 1'b0;
    chk("spur_no_done", 64'(req_done), 64'(0));
    chk("spur_not_busy", 64'(busy), 64'(0));
    next_cycle();
    chk("spur_no_done2", 64'(req_done), 64'(0));

    // single requester, done 4 cycles after ISSUE
    run_txn(2'b01, 0, 4, 1'b0, 1'b0, 1'b1, 64'h1234, o, off);
    chk("single_latency", 64'(off), 64'(1));
    chk("single_owner", 64'(o), 64'(0));
    chk("single_busy_cycles", 64'(busy_cycles), 64'(5));

    // core_done in the very last WAIT cycle beats the watchdog
    run_txn(2'b10, 0, WD_WAIT, 1'b0, 1'b1, 1'b0, 64'h0, o, off);
    chk("late_done_no_to", 64'(timeout_err), 64'(0));

    // contention from reset: 0,1,0,1
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    model_reset();
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      run_txn(2'b11, 0, 1, 1'b0, 1'b0, 1'b0, 64'h0, o, off);
      chk("contention_order", 64'(o), 64'(k % 2));
    end

    // holdoff on requester 0
    run_txn(2'b01, 0, 1, 1'b0, 1'b0, 1'b0, 64'h0, o, off);
    run_txn(2'b01, 0, 1, 1'b0, 1'b0, 1'b0, 64'h0, o, off);
    chk("holdoff_delay", 64'(off), 64'(HOLD + 1));
    run_txn(2'b11, 0, 2, 1'b1, 1'b0, 1'b0, 64'h0, o, off);
    chk("holdoff_other_first", 64'(o), 64'(1));

    // watchdog
    run_txn(2'b01, 1, 0, 1'b0, 1'b0, 1'b0, 64'h0, o, off);
    chk("wd_sticky", 64'(timeout_err), 64'(1));
    run_txn(2'b01, 0, 3, 1'b0, 1'b0, 1'b0, 64'h0, o, off);

    // reset during WAIT
    req_cmd[LC +: LC] = 64'hDEAD_BEEF_0000_0001;
    req_we = 2'b10;
    next_cycle();
    chk("midrst_issue", 64'(core_we), 64'(1));
    next_cycle();
    req_we = 2'b00;
    rst = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    next_cycle();
    chk("midrst_no_done", 64'(req_done), 64'(0));
    rst = 1'b1;
    model_reset();
    next_cycle();
    chk("postrst_no_done", 64'(req_done), 64'(0));
    run_txn(2'b10, 0, 2, 1'b0, 1'b0, 1'b0, 64'h0, o, off);
    chk("postrst_owner", 64'(o), 64'(1));

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      run_txn(2'($urandom_range(3, 1)), int'($urandom_range(2, 0)),
              int'($urandom_range(6, 1)), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)), 1'b0, 64'h0, o, off);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
